// File: rtl/ysyx_220066_clint.sv
// ysyx_220066_clint -- core-local interruptor.
//
// Holds mtime, mtimecmp and msip behind a single-outstanding valid/ready MMIO
// port and drives the CSR unit's machine timer / software interrupt request.
// Requests are gated by mstatus.MIE and issued once per trap through an
// "armed" flag that re-arms whenever MIE is seen low.
//
// Build option:
//   CLINT_MSIP_EN  defined   -> msip register implemented at offset 0x0000.
//                  undefined -> offset 0x0000 decodes but reads 0 and ignores
//                               writes; the software interrupt never pends.
//
// Register map (byte offset, bits [2:0] ignored):
//   0x0000 msip      (bit 0 only)
//   0x4000 mtimecmp
//   0xBFF8 mtime
//   anything else -> resp_err, read data 0, writes dropped

module ysyx_220066_clint #(
    parameter int TICK_DIV = 1,   // clk cycles per mtime increment, >= 1
    parameter int ADDR_W   = 16   // width of the offset inside the CLINT window
) (
    input  logic              clk,
    input  logic              rst,

    // MMIO request channel from the LSU
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wmask,

    // MMIO response channel to the LSU
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,

    // Trap interface to the CSR unit
    input  logic              mstatus_mie,
    input  logic              intr_ack,
    output logic              raise_intr,
    output logic [63:0]       NO
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] OFF_MSIP     = ADDR_W'('h0000);
    localparam logic [ADDR_W-1:0] OFF_MTIMECMP = ADDR_W'('h4000);
    localparam logic [ADDR_W-1:0] OFF_MTIME    = ADDR_W'('hBFF8);

    // mcause values: interrupt bit set, cause 3 = MSI, cause 7 = MTI
    localparam logic [63:0] CAUSE_MSI = {1'b1, 63'd3};
    localparam logic [63:0] CAUSE_MTI = {1'b1, 63'd7};

    // Prescaler width; a single bit is kept even when TICK_DIV == 1 so the
    // counter never collapses to a zero-width vector.
    localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state;
    logic [PS_W-1:0] prescaler;
    logic [63:0]     mtime;
    logic [63:0]     mtimecmp;
    logic            armed;

    // ------------------------------------------------------------------
    // Address decode and access strobes
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] offset;
    logic              hit_msip;
    logic              hit_mtimecmp;
    logic              hit_mtime;
    logic              hit_any;
    logic              accept;
    logic              wr_en;

    // The low three address bits select a byte inside a 64-bit register and
    // are covered by req_wmask instead.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[2:0];

    assign offset       = {req_addr[ADDR_W-1:3], 3'b000};
    assign hit_msip     = (offset == OFF_MSIP);
    assign hit_mtimecmp = (offset == OFF_MTIMECMP);
    assign hit_mtime    = (offset == OFF_MTIME);
    assign hit_any      = hit_msip | hit_mtimecmp | hit_mtime;

    // A request is taken only while idle; the access itself happens on the
    // same edge that moves the FSM to RESP.
    assign accept = (state == S_IDLE) && req_valid;
    assign wr_en  = accept && req_wen;

    // Byte-lane merge of write data into an existing 64-bit register.
    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old_val,
        input logic [63:0] wdata,
        input logic [7:0]  wmask
    );
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (wmask[i]) begin
                res[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Software interrupt pending bit
    // ------------------------------------------------------------------
    logic msip_p;

`ifdef CLINT_MSIP_EN
    logic msip_q;

    // msip register: only bit 0 exists, written through byte lane 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            msip_q <= 1'b0;
        end else if (wr_en && hit_msip && req_wmask[0]) begin
            msip_q <= req_wdata[0];
        end
    end

    assign msip_p = msip_q;
`else
    assign msip_p = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read data mux (values before any same-edge update)
    // ------------------------------------------------------------------
    logic [63:0] rd_data;

    // Select the addressed register; unmapped offsets read as zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        rd_data = 64'd0;
        if (hit_msip) begin
            rd_data = {63'd0, msip_p};
        end else if (hit_mtimecmp) begin
            rd_data = mtimecmp;
        end else if (hit_mtime) begin
            rd_data = mtime;
        end
    end

    // ------------------------------------------------------------------
    // MMIO handshake FSM with registered outputs
    // ------------------------------------------------------------------

    // IDLE accepts one request and latches its response; RESP holds the
    // response stable until the LSU takes it, with no same-cycle re-accept.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state      <= S_RESP;
                        req_ready  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= req_wen ? 64'd0 : rd_data;
                        resp_err   <= ~hit_any;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic tick;

    assign tick = (prescaler == PS_LAST);

    // Prescaler counts 0..TICK_DIV-1 and is never disturbed by MMIO writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // mtime: a software write wins over a coincident tick, which is dropped.
    // The increment wraps modulo 2^64 silently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime <= 64'd0;
        end else if (wr_en && hit_mtime) begin
            mtime <= merge_bytes(mtime, req_wdata, req_wmask);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp: resets to all-ones so the timer interrupt stays quiet until
    // software programs a deadline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_en && hit_mtimecmp) begin
            mtimecmp <= merge_bytes(mtimecmp, req_wdata, req_wmask);
        end
    end

    // ------------------------------------------------------------------
    // Interrupt request generation
    // ------------------------------------------------------------------
    logic mtip;
    logic raise_next;

    assign mtip       = (mtime >= mtimecmp);
    assign raise_next = armed & mstatus_mie & (msip_p | mtip) & ~intr_ack;

    // Registered trap request; the cause is captured only while a request is
    // being driven so it holds its last value once the request drops.
    // armed is cleared by the CSR unit's acknowledge and restored whenever MIE
    // is low (trap entry clears it, mret restores it); low MIE wins over ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            raise_intr <= 1'b0;
            NO         <= 64'd0;
            armed      <= 1'b1;
        end else begin
            raise_intr <= raise_next;
            if (raise_next) begin
                NO <= msip_p ? CAUSE_MSI : CAUSE_MTI;
            end
            if (!mstatus_mie) begin
                armed <= 1'b1;
            end else if (intr_ack) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_220066_clint.sv
// tb_ysyx_220066_clint -- directed bench for the CLINT.
// A driver issues MMIO accesses and pushes the expected response into a
// queue; a separate monitor pops and compares whenever a response retires.
// Timer expectations come from a small reference model of mtime/mtimecmp.

module tb_ysyx_220066_clint;

    localparam int          TICK_DIV = 4;
    localparam logic [63:0] ALL1     = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MTI      = 64'h8000_0000_0000_0007;
    localparam logic [63:0] MSI      = 64'h8000_0000_0000_0003;
`ifdef CLINT_MSIP_EN
    localparam bit MSIP_ON = 1'b1;
`else
    localparam bit MSIP_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mstatus_mie;
    logic        intr_ack;
    logic        raise_intr;
    logic [63:0] NO;

    ysyx_220066_clint #(
        .TICK_DIV (TICK_DIV),
        .ADDR_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mstatus_mie (mstatus_mie),
        .intr_ack    (intr_ack),
        .raise_intr  (raise_intr),
        .NO          (NO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic mapped(input logic [15:0] a);
        logic [15:0] o;
        o = {a[15:3], 3'b000};
        return (o == 16'h0000) || (o == 16'h4000) || (o == 16'hBFF8);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_val, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old_val;
        for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model of the timebase (driven only by bench signals)
    // ------------------------------------------------------------------
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    int          m_ps;

    always @(posedge clk) begin
        if (!rst) begin
            m_time <= 64'd0;
            m_cmp  <= ALL1;
            m_ps   <= 0;
        end else begin
            m_ps <= (m_ps == TICK_DIV - 1) ? 0 : m_ps + 1;
            if (req_valid && req_wen && {req_addr[15:3], 3'b000} == 16'hBFF8)
                m_time <= merge(m_time, req_wdata, req_wmask);
            else if (m_ps == TICK_DIV - 1)
                m_time <= m_time + 64'd1;
            if (req_valid && req_wen && {req_addr[15:3], 3'b000} == 16'h4000)
                m_cmp <= merge(m_cmp, req_wdata, req_wmask);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops an expectation whenever a response retires
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got rdata %h with no request queued", resp_rdata);
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: one MMIO access, called at a negedge, returns at a negedge
    // after the response has retired. hold = cycles with resp_ready low.
    // ------------------------------------------------------------------
    task automatic do_access(input logic wen, input logic [15:0] addr, input logic [63:0] wdata,
                             input logic [7:0] wmask, input logic [63:0] exp_rdata, input int hold);
        int waited;
        exp_t e;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wmask  = wmask;
        resp_ready = (hold == 0);
        e.rdata = wen ? 64'd0 : exp_rdata;
        e.err   = ~mapped(addr);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            check("resp_valid_held", {63'd0, resp_valid}, 64'd1);
            check("req_ready_busy", {63'd0, req_ready}, 64'd0);
            if (i == hold) resp_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        check("resp_retired", {63'd0, resp_valid}, 64'd0);
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int waited;
        rst         = 1'b0;
        req_valid   = 1'b0;
        req_wen     = 1'b0;
        req_addr    = 16'h0;
        req_wdata   = 64'h0;
        req_wmask   = 8'h0;
        resp_ready  = 1'b1;
        mstatus_mie = 1'b0;
        intr_ack    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", {63'd0, resp_err}, 64'd0);
        check("rst_raise", {63'd0, raise_intr}, 64'd0);
        check("rst_NO", NO, 64'd0);
        rst = 1'b1;

        // Reset values of mtimecmp and mtime
        do_access(1'b0, 16'h4000, 64'd0, 8'h00, ALL1, 0);
        do_access(1'b0, 16'hBFF8, 64'd0, 8'h00, m_time, 0);
        check("raise_after_reset", {63'd0, raise_intr}, 64'd0);

        // Low-byte write to mtime with a stalled response, then read back
        do_access(1'b1, 16'hBFF8, 64'h10, 8'h01, 64'd0, 3);
        do_access(1'b0, 16'hBFF8, 64'd0, 8'h00, m_time, 0);

        // Zero wmask is a no-op
        do_access(1'b1, 16'h4000, 64'h0, 8'h00, 64'd0, 0);
        do_access(1'b0, 16'h4000, 64'd0, 8'h00, ALL1, 0);

        // Unmapped offset: error flag, zero data, no side effect
        do_access(1'b0, 16'h1234, 64'd0, 8'h00, 64'd0, 0);
        do_access(1'b1, 16'h1234, ALL1, 8'hFF, 64'd0, 0);
        do_access(1'b0, 16'h4003, 64'd0, 8'h00, ALL1, 0);

        // mtime wraps modulo 2^64; MIE=0 keeps the request low
        do_access(1'b1, 16'hBFF8, ALL1, 8'hFF, 64'd0, 0);
        do_access(1'b0, 16'hBFF8, 64'd0, 8'h00, m_time, 0);
        check("raise_gated_by_mie", {63'd0, raise_intr}, 64'd0);
        repeat (8) @(negedge clk);
        do_access(1'b0, 16'hBFF8, 64'd0, 8'h00, m_time, 0);

        // Write to mtime on the tick edge: written value wins exactly
        waited = 0;
        while (m_ps != TICK_DIV - 1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        do_access(1'b1, 16'hBFF8, 64'h1234_5678_9ABC_DEF0, 8'hFF, 64'd0, 0);
        do_access(1'b0, 16'hBFF8, 64'd0, 8'h00, 64'h1234_5678_9ABC_DEF0, 0);

        // Timer interrupt: raise one cycle after mtime reaches mtimecmp
        mstatus_mie = 1'b1;
        do_access(1'b1, 16'hBFF8, 64'd0, 8'hFF, 64'd0, 0);
        do_access(1'b1, 16'h4000, 64'd5, 8'hFF, 64'd0, 0);
        waited = 0;
        while (m_time != 64'd5 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("raise_before_match", {63'd0, raise_intr}, 64'd0);
        @(negedge clk);
        check("raise_on_match", {63'd0, raise_intr}, 64'd1);
        check("NO_timer", NO, MTI);

        // Acknowledge disarms; dropping MIE re-arms
        intr_ack = 1'b1;
        @(negedge clk);
        intr_ack = 1'b0;
        check("raise_after_ack", {63'd0, raise_intr}, 64'd0);
        repeat (3) @(negedge clk);
        check("raise_stays_low", {63'd0, raise_intr}, 64'd0);
        mstatus_mie = 1'b0;
        @(negedge clk);
        mstatus_mie = 1'b1;
        check("raise_mie_low", {63'd0, raise_intr}, 64'd0);
        @(negedge clk);
        check("raise_rearmed", {63'd0, raise_intr}, 64'd1);

        // Ack together with MIE low leaves the block armed
        intr_ack    = 1'b1;
        mstatus_mie = 1'b0;
        @(negedge clk);
        intr_ack    = 1'b0;
        mstatus_mie = 1'b1;
        @(negedge clk);
        check("raise_ack_and_mie_low", {63'd0, raise_intr}, 64'd1);

        // Software interrupt priority (or its absence)
        do_access(1'b1, 16'h0000, 64'd1, 8'h01, 64'd0, 0);
        check("NO_msip", NO, MSIP_ON ? MSI : MTI);
        check("raise_with_msip", {63'd0, raise_intr}, 64'd1);
        do_access(1'b0, 16'h0000, 64'd0, 8'h00, {63'd0, MSIP_ON}, 0);
        do_access(1'b1, 16'h0000, 64'd0, 8'h01, 64'd0, 0);
        check("NO_after_msip_clear", NO, MTI);

        // Software clears the timer source
        do_access(1'b1, 16'h4000, ALL1, 8'hFF, 64'd0, 0);
        check("raise_cleared", {63'd0, raise_intr}, 64'd0);
        check("NO_holds", NO, MTI);

        // Reset in the middle of a transaction
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_addr   = 16'hBFF8;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_resp_valid", {63'd0, resp_valid}, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("mid_rst_raise", {63'd0, raise_intr}, 64'd0);
        rst        = 1'b1;
        resp_ready = 1'b1;
        do_access(1'b0, 16'hBFF8, 64'd0, 8'h00, m_time, 0);
        do_access(1'b0, 16'h4000, 64'd0, 8'h00, ALL1, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_clint.md
Name: ysyx_220066_clint

Overview:
- Core-local interruptor that sits directly upstream of the CSR unit.
- Holds the mtime, mtimecmp and msip registers, which the LSU reads and writes over a single-outstanding valid/ready MMIO port.
- Drives the CSR unit's trap inputs: raise_intr, plus the cause value NO with the interrupt bit set.
- Gates those requests with mstatus.MIE, which the CSR unit supplies.

Parameters:
- TICK_DIV, 1: clk cycles per mtime increment; must be >=1.
- ADDR_W, 16: width of the offset address within the CLINT window.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- req_valid  in  1  MMIO request valid
- req_ready  out  1  block can accept a request
- req_wen  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte offset; bits [2:0] ignored
- req_wdata  in  64  write data
- req_wmask  in  8  byte enables for writes
- resp_valid  out  1  response valid
- resp_ready  in  1  LSU accepts response
- resp_rdata  out  64  read data; 0 for writes
- resp_err  out  1  unmapped offset
- mstatus_mie  in  1  global interrupt enable from the CSR unit
- intr_ack  in  1  CSR unit took the trap this cycle
- raise_intr  out  1  interrupt request to the CSR unit
- NO  out  64  mcause value to the CSR unit

Behaviour:
- Reset (rst==0 at posedge), with every output registered:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - FSM=IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - raise_intr=0, NO=0, armed=1.
- Register map, by req_addr[ADDR_W-1:3]<<3:
  - 0x0000 msip: bit0 only; other bits read 0.
  - 0x4000 mtimecmp.
  - 0xBFF8 mtime.
  - Any other offset sets resp_err=1; reads return 0 and writes have no effect.
- Writes merge byte-wise under req_wmask. A wmask of 0 is legal and is a no-op.
- FSM IDLE:
  - req_ready=1.
  - On req_valid: perform the access at that posedge, latch resp_rdata/resp_err, then go to RESP.
- FSM RESP:
  - req_ready=0 and resp_valid=1.
  - Hold resp_rdata/resp_err stable until resp_ready, then return to IDLE.
  - No back-to-back accept in the cycle the response retires.
- Read latency: 1 cycle. Reads return the value before any same-cycle tick.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - On wrap, mtime increments by 1 and wraps modulo 2^64 with no flag.
- A write to mtime in the same cycle as a tick: the written value wins and the tick is dropped. The prescaler is not reset by the write.
- Pending bits:
  - mtip = (mtime >= mtimecmp), unsigned, computed from current register values.
  - msip_p = msip[0].
- raise_intr is registered. Next value = armed & mstatus_mie & (msip_p | mtip) & ~intr_ack.
- NO, registered alongside raise_intr:
  - msip_p has priority: {1'b1, 63'd3}.
  - Otherwise mtip: {1'b1, 63'd7}.
  - NO holds its value while raise_intr is 0.
- Arming:
  - intr_ack clears armed.
  - armed sets again in any cycle where mstatus_mie==0 (trap entry clears MIE; mret restores it), so one request is issued per trap.
  - intr_ack and mstatus_mie==0 in the same cycle: armed=1.
- Software clearing a source, whether by writing mtimecmp > mtime or writing msip=0, drops raise_intr on the following cycle.
- Reset mid-transaction: abandon the response, resp_valid=0 and FSM=IDLE next cycle.

Optional Feature:
- Macro CLINT_MSIP_EN.
- Defined: msip register is implemented as above.
- Undefined:
  - Offset 0x0000 still decodes with resp_err=0, but reads 0 and ignores writes.
  - msip_p is tied 0, so NO is only ever {1'b1, 63'd7}.

Test Plan:
- Reset, then read 0x4000 and 0xBFF8 -> rdata=FFFF_FFFF_FFFF_FFFF and 0; resp_valid exactly 1 cycle after accept; raise_intr=0.
- Write mtime=0x10 with wmask=0x01, hold resp_ready=0 for 3 cycles -> resp_valid held 3+ cycles, req_ready=0 throughout; subsequent read of mtime ≥0x10.
- TICK_DIV=4, write mtime=0, mtimecmp=5, mstatus_mie=1 -> raise_intr rises the cycle after mtime reaches 5, with NO=8000_0000_0000_0007.
- With raise_intr=1, pulse intr_ack while holding MIE=1 -> raise_intr=0 next cycle and stays 0; drop MIE for 1 cycle, restore -> raise_intr=1 again.
- CLINT_MSIP_EN defined: write msip=1 while mtip=1 -> NO=8000_0000_0000_0003. Undefined: the same write leaves NO=...0007 and a read of 0x0000 returns 0.
- Read offset 0x1234 -> resp_err=1, rdata=0; write mtime with a tick in the same cycle -> read back equals the written value exactly.
